// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: samples DataPath nets into a FIFO while armed and streams
// each record out as four 32-bit beats. Optional build macro: TRACE_WRITE_FILTER_EN.
module trace_capture_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STOP_COUNT = 20
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        arm,
  input  logic [31:0] pcQ,
  input  logic [31:0] instruction,
  input  logic        regWriteEnable,
  input  logic [31:0] aluResult,
  output logic [31:0] traceData,
  output logic        traceValid,
  input  logic        traceReady,
  output logic        traceLast,
  output logic        capturing,
  output logic        done,
  output logic        overflow,
  output logic [15:0] cycleCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [15:0] LastCount = 16'(STOP_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} stateT;

  stateT       stateQ, stateD;
  logic [AW:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [1:0]  beatQ, beatD;
  logic [15:0] cycleCountQ, cycleCountD;
  logic        overflowQ, overflowD;
  logic        armPrevQ;

  logic [31:0] memPc    [DEPTH];
  logic [31:0] memInstr [DEPTH];
  logic [31:0] memAlu   [DEPTH];
  logic        memRwe   [DEPTH];
  logic [15:0] memStamp [DEPTH];

  logic          armRise, fifoEmpty, fifoFull, handshake, popRec, recordEn, wrEn;
  logic [AW-1:0] headIdx;

  assign armRise   = arm & ~armPrevQ;
  assign fifoEmpty = (wrPtrQ == rdPtrQ);
  assign fifoFull  = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign handshake = traceValid & traceReady;
  assign popRec    = handshake && (beatQ == 2'd3);
  assign headIdx   = rdPtrQ[AW-1:0];

`ifdef TRACE_WRITE_FILTER_EN
  assign recordEn = regWriteEnable;
`else
  assign recordEn = 1'b1;
`endif

  always_comb begin
    stateD      = stateQ;
    wrPtrD      = wrPtrQ;
    rdPtrD      = rdPtrQ;
    beatD       = beatQ;
    cycleCountD = cycleCountQ;
    overflowD   = overflowQ;
    wrEn        = 1'b0;

    if (handshake) beatD = beatQ + 2'd1;
    if (popRec) rdPtrD = rdPtrQ + {{AW{1'b0}}, 1'b1};

    unique case (stateQ)
      StIdle, StDone: begin
        if (armRise) begin
          stateD      = StCapture;
          cycleCountD = '0;
          overflowD   = 1'b0;
          wrPtrD      = '0;
          rdPtrD      = '0;
          beatD       = '0;
        end
      end
      StCapture: begin
        if (!arm) begin
          stateD = StDrain;
        end else begin
          // Full is judged on registered pointers: a same-cycle pop frees nothing.
          if (recordEn) begin
            if (fifoFull) overflowD = 1'b1;
            else          wrEn      = 1'b1;
          end
          cycleCountD = cycleCountQ + 16'd1;
          if (cycleCountQ == LastCount) stateD = StDrain;
        end
      end
      StDrain: begin
        if (fifoEmpty && (beatQ == 2'd0)) stateD = StDone;
      end
      default: stateD = StIdle;
    endcase

    if (wrEn) wrPtrD = wrPtrQ + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateQ      <= StIdle;
      wrPtrQ      <= '0;
      rdPtrQ      <= '0;
      beatQ       <= '0;
      cycleCountQ <= '0;
      overflowQ   <= 1'b0;
      armPrevQ    <= 1'b0;
    end else begin
      stateQ      <= stateD;
      wrPtrQ      <= wrPtrD;
      rdPtrQ      <= rdPtrD;
      beatQ       <= beatD;
      cycleCountQ <= cycleCountD;
      overflowQ   <= overflowD;
      armPrevQ    <= arm;
    end
  end

  always_ff @(posedge clock) begin
    if (wrEn) begin
      memPc[wrPtrQ[AW-1:0]]    <= pcQ;
      memInstr[wrPtrQ[AW-1:0]] <= instruction;
      memAlu[wrPtrQ[AW-1:0]]   <= aluResult;
      memRwe[wrPtrQ[AW-1:0]]   <= regWriteEnable;
      memStamp[wrPtrQ[AW-1:0]] <= cycleCountQ;
    end
  end

  always_comb begin
    traceValid = !fifoEmpty;
    traceData  = '0;
    traceLast  = 1'b0;
    if (!fifoEmpty) begin
      unique case (beatQ)
        2'd0: traceData = memPc[headIdx];
        2'd1: traceData = memInstr[headIdx];
        2'd2: traceData = memAlu[headIdx];
        2'd3: begin
          traceData = {memStamp[headIdx], 15'b0, memRwe[headIdx]};
          traceLast = 1'b1;
        end
        default: traceData = '0;
      endcase
    end
  end

  assign capturing  = (stateQ == StCapture);
  assign done       = (stateQ == StDone);
  assign overflow   = overflowQ;
  assign cycleCount = cycleCountQ;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: one instance with STOP_COUNT=4 (A) and one
// with STOP_COUNT=20 (B), sharing clock, reset and DataPath inputs.
module tb_trace_capture_buffer;

  logic        clock = 1'b0;
  logic        resetN;
  logic        armA, armB, readyA, readyB;
  logic [31:0] pcQ, instruction, aluResult;
  logic        regWriteEnable;

  logic [31:0] dataA, dataB;
  logic        validA, validB, lastA, lastB, capA, capB, doneA, doneB, ovfA, ovfB;
  logic [15:0] cntA, cntB;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  trace_capture_buffer #(.DEPTH(16), .STOP_COUNT(4)) dutA (
    .clock(clock), .resetN(resetN), .arm(armA), .pcQ(pcQ), .instruction(instruction),
    .regWriteEnable(regWriteEnable), .aluResult(aluResult), .traceData(dataA),
    .traceValid(validA), .traceReady(readyA), .traceLast(lastA), .capturing(capA),
    .done(doneA), .overflow(ovfA), .cycleCount(cntA)
  );

  trace_capture_buffer #(.DEPTH(16), .STOP_COUNT(20)) dutB (
    .clock(clock), .resetN(resetN), .arm(armB), .pcQ(pcQ), .instruction(instruction),
    .regWriteEnable(regWriteEnable), .aluResult(aluResult), .traceData(dataB),
    .traceValid(validB), .traceReady(readyB), .traceLast(lastB), .capturing(capB),
    .done(doneB), .overflow(ovfB), .cycleCount(cntB)
  );

  function automatic logic [31:0] pcOf(int run, int k);
    return 32'h0040_0000 + 32'(run << 16) + 32'(k << 2);
  endfunction

  function automatic logic [31:0] instrOf(int run, int k);
    return 32'h0000_0013 + 32'(run << 20) + 32'(k << 7);
  endfunction

  function automatic logic [31:0] aluOf(int run, int k);
    return 32'hA5A5_0000 ^ 32'(run << 8) ^ 32'(k);
  endfunction

  function automatic logic [31:0] beatOf(int run, int k, int beat, logic rwe);
    logic [15:0] stamp;
    stamp = 16'(k);
    case (beat)
      0:       return pcOf(run, k);
      1:       return instrOf(run, k);
      2:       return aluOf(run, k);
      default: return {stamp, 15'b0, rwe};
    endcase
  endfunction

  task automatic drive(input int run, input int k, input logic rwe);
    pcQ            = pcOf(run, k);
    instruction    = instrOf(run, k);
    aluResult      = aluOf(run, k);
    regWriteEnable = rwe;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input int run, input int k, input int beat,
                           input logic rwe, input logic v, input logic [31:0] d,
                           input logic l);
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_data"}, d, beatOf(run, k, beat, rwe));
    chk({tag, "_last"}, 32'(l), 32'(beat == 3));
  endtask

  logic [3:0] basicRwe;
  int         recs[$];

  initial begin
    basicRwe = 4'b1101;  // record k uses bit k: 1,0,1,1
`ifdef TRACE_WRITE_FILTER_EN
    recs = '{0, 2, 3};
`else
    recs = '{0, 1, 2, 3};
`endif
    resetN = 1'b0;
    armA = 1'b0; armB = 1'b0; readyA = 1'b1; readyB = 1'b0;
    drive(0, 0, 1'b0);

    // Reset state
    @(negedge clock);
    chk("rst_valid", 32'(validA), 32'd0);
    chk("rst_data", dataA, 32'd0);
    chk("rst_last", 32'(lastA), 32'd0);
    chk("rst_capturing", 32'(capA), 32'd0);
    chk("rst_done", 32'(doneA), 32'd0);
    chk("rst_overflow", 32'(ovfA), 32'd0);
    chk("rst_count", 32'(cntA), 32'd0);
    resetN = 1'b1;
    @(negedge clock);

    // Basic run on A, traceReady held high
    armA = 1'b1;
    drive(1, 0, basicRwe[0]);
    @(negedge clock);
    chk("basic_capturing", 32'(capA), 32'd1);
    chk("basic_count0", 32'(cntA), 32'd0);
    chk("basic_novalid", 32'(validA), 32'd0);
    for (int i = 0; i < recs.size() * 4; i++) begin
      @(negedge clock);
      if (i < 3) drive(1, i + 1, basicRwe[i + 1]);
      checkBeat($sformatf("basic_b%0d", i), 1, recs[i / 4], i % 4, basicRwe[recs[i / 4]],
                validA, dataA, lastA);
    end
    armA = 1'b0;
    for (int n = 0; n < 20 && !doneA; n++) @(negedge clock);
    chk("basic_done", 32'(doneA), 32'd1);
    chk("basic_overflow", 32'(ovfA), 32'd0);
    chk("basic_count", 32'(cntA), 32'd4);
    chk("basic_empty", 32'(validA), 32'd0);

    // Overflow run on B, traceReady low throughout capture
    armB = 1'b1;
    drive(2, 0, 1'b1);
    @(negedge clock);
    for (int k = 1; k < 20; k++) begin
      @(negedge clock);
      drive(2, k, 1'b1);
    end
    @(negedge clock);
    chk("ovf_capturing", 32'(capB), 32'd0);
    chk("ovf_count", 32'(cntB), 32'd20);
    chk("ovf_flag", 32'(ovfB), 32'd1);
    chk("ovf_done", 32'(doneB), 32'd0);
    checkBeat("ovf_b0", 2, 0, 0, 1'b1, validB, dataB, lastB);
    armB = 1'b0;

    // Backpressure inside record 0: ready 1,0,0,1
    readyB = 1'b1;
    @(negedge clock);
    readyB = 1'b0;
    checkBeat("bp_b1a", 2, 0, 1, 1'b1, validB, dataB, lastB);
    @(negedge clock);
    checkBeat("bp_b1b", 2, 0, 1, 1'b1, validB, dataB, lastB);
    @(negedge clock);
    readyB = 1'b1;
    checkBeat("bp_b1c", 2, 0, 1, 1'b1, validB, dataB, lastB);
    for (int j = 2; j < 64; j++) begin
      @(negedge clock);
      checkBeat($sformatf("ovf_b%0d", j), 2, j / 4, j % 4, 1'b1, validB, dataB, lastB);
    end
    for (int n = 0; n < 20 && !doneB; n++) @(negedge clock);
    chk("ovf_drain_done", 32'(doneB), 32'd1);
    chk("ovf_drain_empty", 32'(validB), 32'd0);
    chk("ovf_sticky", 32'(ovfB), 32'd1);
    readyB = 1'b0;

    // Early stop on A: arm dropped after 3 capture cycles
    armA = 1'b1;
    drive(3, 0, 1'b1);
    @(negedge clock);
    chk("early_rearm", 32'(capA), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i < 2) drive(3, i + 1, 1'b1);
      if (i == 2) begin
        chk("early_still_capturing", 32'(capA), 32'd1);
        armA = 1'b0;
      end
      if (i == 3) begin
        chk("early_drain", 32'(capA), 32'd0);
        chk("early_count", 32'(cntA), 32'd3);
      end
      checkBeat($sformatf("early_b%0d", i), 3, i / 4, i % 4, 1'b1, validA, dataA, lastA);
    end
    for (int n = 0; n < 20 && !doneA; n++) @(negedge clock);
    chk("early_done", 32'(doneA), 32'd1);
    chk("early_overflow", 32'(ovfA), 32'd0);

    // Async reset on B with 5 records queued
    armB = 1'b1;
    drive(4, 0, 1'b1);
    @(negedge clock);
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      drive(4, k, 1'b1);
    end
    @(negedge clock);
    armB = 1'b0;
    @(negedge clock);
    chk("rstmid_count", 32'(cntB), 32'd5);
    checkBeat("rstmid_b0", 4, 0, 0, 1'b1, validB, dataB, lastB);
    #2 resetN = 1'b0;
    #1;
    chk("rstmid_valid", 32'(validB), 32'd0);
    chk("rstmid_data", dataB, 32'd0);
    chk("rstmid_last", 32'(lastB), 32'd0);
    chk("rstmid_count0", 32'(cntB), 32'd0);
    chk("rstmid_overflow", 32'(ovfB), 32'd0);
    chk("rstmid_doneA", 32'(doneA), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_valid", 32'(validB), 32'd0);
    chk("post_rst_done", 32'(doneB), 32'd0);
    chk("post_rst_capturing", 32'(capB), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
